dvsd_pd_stream: RTL and testbench

//  Receive-side decoder for the dvsd_pe 8:3 priority-encoder output {out[2:0], gs, eno}.

---
 rtl/dvsd_pd_stream.sv | 135 +++++++++++++
 tb/tb_dvsd_pd_stream.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvsd_pd_stream.sv
// -----------------------------------------------------------------------------
// dvsd_pd_stream
//   Receive-side decoder for the dvsd_pe 8:3 priority-encoder word
//   {code[2:0], gs, eno}. Words arrive over valid/ready, are decoded back to
//   the one-hot request and queued in a small FIFO. The block also keeps:
//   a sticky mask of every line seen, a saturating count of gs words, and a
//   sticky error flag for the illegal gs=1/eno=1 combination.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake (in_ready = !full, low in reset)
//   in_code/gs/eno      encoder word
//   out_valid/out_ready output handshake on the FIFO head
//   out_onehot/none/dis decoded head word (all zero when out_valid=0)
//   seen, seen_clr      sticky OR of accepted one-hots, sync clear
//   evt_cnt             saturating count of accepted gs=1 words
//   err                 sticky illegal-word flag, cleared only by reset
// -----------------------------------------------------------------------------
module dvsd_pd_stream #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  input  logic             in_gs,
  input  logic             in_eno,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_onehot,
  output logic             out_none,
  output logic             out_dis,
  output logic [7:0]       seen,
  input  logic             seen_clr,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             err
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  // Entry layout: {dis, none, onehot[7:0]}
  logic [9:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic [7:0]       seen_q, seen_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic             err_q, err_d;

  logic       full, empty, accept, illegal, push, pop;
  logic [7:0] dec_onehot;
  logic       dec_none, dec_dis;
  logic [9:0] head;

  assign full  = (cnt_q == FULL_C);
  assign empty = (cnt_q == '0);

  // Gating with rst_n keeps the handshake closed while reset is asserted;
  // after release an empty FIFO accepts immediately.
  assign in_ready  = rst_n & ~full;
  assign out_valid = ~empty;

  assign accept  = in_valid & in_ready;
  assign illegal = in_gs & in_eno;
  // Illegal words complete the handshake but never enter the FIFO.
  assign push    = accept & ~illegal;
  // pop qualifies on out_valid, so an empty FIFO ignores out_ready even when
  // a push lands on the same edge.
  assign pop     = out_valid & out_ready;

  always_comb begin
    dec_onehot = '0;
    if (in_gs) dec_onehot = 8'b1 << in_code;
  end
  assign dec_none = ~in_gs & in_eno;
  assign dec_dis  = ~in_gs & ~in_eno;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    seen_d = seen_clr ? 8'h00 : seen_q;
    if (push) seen_d = seen_d | dec_onehot;
  end

  always_comb begin
    evt_d = evt_q;
    if (push && in_gs && (evt_q != {CNT_W{1'b1}})) evt_d = evt_q + 1'b1;
  end

  always_comb begin
    err_d = err_q;
    if (accept && illegal) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      seen_q   <= '0;
      evt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {dec_dis, dec_none, dec_onehot};
        wr_ptr_q        <= wr_ptr_q + 1'b1;  // DEPTH is a power of two: wraps
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      evt_q  <= evt_d;
      err_q  <= err_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_onehot = out_valid ? head[7:0] : 8'h00;
  assign out_none   = out_valid & head[8];
  assign out_dis    = out_valid & head[9];

  assign seen    = seen_q;
  assign evt_cnt = evt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dvsd_pd_stream.sv
// -----------------------------------------------------------------------------
// tb_dvsd_pd_stream
//   Directed bench for dvsd_pd_stream. u_dut uses DEPTH=2, CNT_W=8;
//   u_sat uses CNT_W=2 to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_dvsd_pd_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_gs, in_eno;
  logic [2:0] in_code;
  logic       out_valid, out_ready, out_none, out_dis;
  logic [7:0] out_onehot, seen;
  logic       seen_clr, err;
  logic [7:0] evt_cnt;

  logic       s_in_valid, s_in_ready, s_in_gs, s_in_eno;
  logic [2:0] s_in_code;
  logic       s_out_valid, s_out_ready, s_out_none, s_out_dis;
  logic [7:0] s_out_onehot, s_seen;
  logic       s_seen_clr, s_err;
  logic [1:0] s_evt_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dvsd_pd_stream #(.DEPTH(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_gs(in_gs), .in_eno(in_eno),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_none(out_none), .out_dis(out_dis),
    .seen(seen), .seen_clr(seen_clr), .evt_cnt(evt_cnt), .err(err)
  );

  dvsd_pd_stream #(.DEPTH(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_code(s_in_code), .in_gs(s_in_gs), .in_eno(s_in_eno),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_onehot(s_out_onehot), .out_none(s_out_none), .out_dis(s_out_dis),
    .seen(s_seen), .seen_clr(s_seen_clr), .evt_cnt(s_evt_cnt), .err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic gs, input logic eno);
    in_valid = v; in_code = c; in_gs = gs; in_eno = eno;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    out_ready = 1'b0; seen_clr = 1'b0;
    s_in_valid = 1'b0; s_in_code = 3'd0; s_in_gs = 1'b0; s_in_eno = 1'b0;
    s_out_ready = 1'b0; s_seen_clr = 1'b0;

    // ---- reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_onehot", out_onehot, 0);
    chk("rst_seen", seen, 0);
    chk("rst_evt", evt_cnt, 0);
    chk("rst_err", err, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // ---- 1: single legal word, code 5
    drive(1'b1, 3'd5, 1'b1, 1'b0);
    step();
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_onehot", out_onehot, 8'h20);
    chk("t1_none", out_none, 0);
    chk("t1_seen", seen, 8'h20);
    chk("t1_evt", evt_cnt, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_pop_valid", out_valid, 0);
    chk("t1_pop_onehot", out_onehot, 0);

    // ---- 2: fill with codes 0 and 7, third word (code 3) stalls
    drive(1'b1, 3'd0, 1'b1, 1'b0);
    step();
    chk("t2_ready_after1", in_ready, 1);
    drive(1'b1, 3'd7, 1'b1, 1'b0);
    step();
    chk("t2_full_ready", in_ready, 0);
    drive(1'b1, 3'd3, 1'b1, 1'b0);
    step();
    chk("t2_stall_ready", in_ready, 0);
    chk("t2_head0", out_onehot, 8'h01);
    chk("t2_evt_stall", evt_cnt, 3);
    // pop while full: in_ready was low, so the stalled word is not taken yet
    out_ready = 1'b1;
    step();
    chk("t2_head1", out_onehot, 8'h80);
    chk("t2_ready_reopen", in_ready, 1);
    // non-empty push+pop: occupancy stays 1, stalled word now at head
    step();
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("t2_head2", out_onehot, 8'h08);
    chk("t2_valid2", out_valid, 1);
    chk("t2_ready2", in_ready, 1);
    chk("t2_evt", evt_cnt, 4);
    step();
    out_ready = 1'b0;
    chk("t2_drained", out_valid, 0);
    chk("t2_seen", seen, 8'hA9);

    // ---- 3: eno word and disabled word
    drive(1'b1, 3'd2, 1'b0, 1'b1);
    step();
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("t3_none", out_none, 1);
    chk("t3_none_onehot", out_onehot, 0);
    chk("t3_none_dis", out_dis, 0);
    out_ready = 1'b1;
    drive(1'b1, 3'd6, 1'b0, 1'b0);
    step();   // pop eno word, push disabled word
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    chk("t3_dis", out_dis, 1);
    chk("t3_dis_none", out_none, 0);
    chk("t3_dis_onehot", out_onehot, 0);
    chk("t3_seen", seen, 8'hA9);
    chk("t3_evt", evt_cnt, 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_drained", out_valid, 0);

    // ---- 4: illegal word is swallowed
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd4, 1'b1, 1'b1);
    step();
    chk("t4_err", err, 1);
    chk("t4_evt", evt_cnt, 5);
    chk("t4_head", out_onehot, 8'h02);
    chk("t4_ready", in_ready, 1);
    chk("t4_seen", seen, 8'hAB);
    drive(1'b1, 3'd6, 1'b1, 1'b0);
    step();
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("t4_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("t4_pop2", out_onehot, 8'h40);
    step();
    out_ready = 1'b0;
    chk("t4_empty", out_valid, 0);
    chk("t4_err_sticky", err, 1);

    // ---- 5: seen clear, then clear+set on the same edge
    seen_clr = 1'b1;
    step();
    seen_clr = 1'b0;
    chk("t5_clr", seen, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 3'(c), 1'b1, 1'b0);
      step();
    end
    chk("t5_seen0F", seen, 8'h0F);
    drive(1'b1, 3'd6, 1'b1, 1'b0);
    seen_clr = 1'b1;
    step();
    seen_clr = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("t5_seen40", seen, 8'h40);
    chk("t5_head", out_onehot, 8'h40);
    chk("t5_evt", evt_cnt, 11);
    step();
    out_ready = 1'b0;

    // saturation on the CNT_W=2 instance
    s_out_ready = 1'b1;
    s_in_valid = 1'b1; s_in_gs = 1'b1; s_in_eno = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_in_code = 3'(k);
      step();
      if (k == 1) chk("t5_sat_cnt2", s_evt_cnt, 2);
    end
    s_in_valid = 1'b0;
    chk("t5_sat_cnt", s_evt_cnt, 3);
    chk("t5_sat_err", s_err, 0);

    // ---- 6: async reset with FIFO full
    drive(1'b1, 3'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd3, 1'b1, 1'b0);
    step();
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("t6_full", in_ready, 0);
    chk("t6_err_pre", err, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_onehot", out_onehot, 0);
    chk("t6_seen", seen, 0);
    chk("t6_evt", evt_cnt, 0);
    chk("t6_err", err, 0);
    chk("t6_ready_inrst", in_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_rel_ready", in_ready, 1);
    chk("t6_rel_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
